// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: EX/MEM register, architectural NZVC flags and the data-memory request handshake.
// Optional feature macro: EX_MEM_FLAG_BYPASS_EN (combinational flag bypass from the execute stage).
module ex_mem_stage #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [WIDTH-1:0]    ex_alu_result,
    input  logic [WIDTH-1:0]    ex_store_data,
    input  logic                ex_is_neg,
    input  logic                ex_is_zero,
    input  logic                ex_is_overflow,
    input  logic                ex_is_carryOut,
    input  logic                ex_set_flags,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_reg_write,
    input  logic [REG_BITS-1:0] ex_Rd,
    input  logic                flush,
    input  logic                dmem_ready,
    input  logic [WIDTH-1:0]    dmem_rdata,
    output logic                mem_stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WIDTH-1:0]    dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    output logic                mem_valid,
    output logic                mem_reg_write,
    output logic                mem_mem_read,
    output logic [REG_BITS-1:0] mem_Rd,
    output logic [WIDTH-1:0]    memalu_result,
    output logic [WIDTH-1:0]    read_data,
    output logic                mem_done,
    output logic                flag_n,
    output logic                flag_z,
    output logic                flag_v,
    output logic                flag_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             capture;
    logic             new_valid;
    logic             new_mem_op;
    logic             mem_write_q;
    logic             is_load;
    logic [WIDTH-1:0] store_data_q;
    logic [3:0]       nzvc_q;

    assign capture    = (state != S_WAIT);
    assign new_valid  = ex_valid & ~flush;
    assign new_mem_op = new_valid & (ex_mem_read | ex_mem_write);
    // A combined read+write is handled as a store, so only pure reads load read_data.
    assign is_load    = mem_mem_read & ~mem_write_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (new_mem_op) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = new_mem_op ? S_WAIT : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mem_stall  = (state == S_WAIT);
    assign dmem_req   = (state == S_WAIT);
    assign mem_done   = (state == S_DONE);
    assign dmem_we    = mem_write_q;
    assign dmem_addr  = memalu_result;
    assign dmem_wdata = store_data_q;

    // Control fields follow the new valid so a bubble can never write or touch memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_Rd        <= '0;
            memalu_result <= '0;
            store_data_q  <= '0;
        end else if (capture) begin
            mem_valid     <= new_valid;
            mem_reg_write <= new_valid & ex_reg_write;
            mem_mem_read  <= new_valid & ex_mem_read;
            mem_write_q   <= new_valid & ex_mem_write;
            mem_Rd        <= ex_Rd;
            memalu_result <= ex_alu_result;
            store_data_q  <= ex_store_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
        end else if ((state == S_WAIT) && dmem_ready && is_load) begin
            read_data <= dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzvc_q <= 4'b0000;
        end else if (capture && new_valid && ex_set_flags) begin
            nzvc_q <= {ex_is_neg, ex_is_zero, ex_is_overflow, ex_is_carryOut};
        end
    end

`ifdef EX_MEM_FLAG_BYPASS_EN
    // Lets a conditional branch right behind a flag-setting instruction see the new flags.
    logic bypass_hit;
    assign bypass_hit = new_valid & ex_set_flags & ~mem_stall;
    assign {flag_n, flag_z, flag_v, flag_c} = bypass_hit ?
        {ex_is_neg, ex_is_zero, ex_is_overflow, ex_is_carryOut} : nzvc_q;
`else
    assign {flag_n, flag_z, flag_v, flag_c} = nzvc_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: reset, table vectors, hand-written handshake sequences
// and a randomized run against a transaction-level reference model.
module tb_ex_mem_stage;

    localparam int WIDTH    = 64;
    localparam int REG_BITS = 5;

    logic                clk;
    logic                reset;
    logic                ex_valid;
    logic [WIDTH-1:0]    ex_alu_result;
    logic [WIDTH-1:0]    ex_store_data;
    logic                ex_is_neg;
    logic                ex_is_zero;
    logic                ex_is_overflow;
    logic                ex_is_carryOut;
    logic                ex_set_flags;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_reg_write;
    logic [REG_BITS-1:0] ex_Rd;
    logic                flush;
    logic                dmem_ready;
    logic [WIDTH-1:0]    dmem_rdata;
    logic                mem_stall;
    logic                dmem_req;
    logic                dmem_we;
    logic [WIDTH-1:0]    dmem_addr;
    logic [WIDTH-1:0]    dmem_wdata;
    logic                mem_valid;
    logic                mem_reg_write;
    logic                mem_mem_read;
    logic [REG_BITS-1:0] mem_Rd;
    logic [WIDTH-1:0]    memalu_result;
    logic [WIDTH-1:0]    read_data;
    logic                mem_done;
    logic                flag_n;
    logic                flag_z;
    logic                flag_v;
    logic                flag_c;

    int checks;
    int failures;

    ex_mem_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_is_neg(ex_is_neg), .ex_is_zero(ex_is_zero),
        .ex_is_overflow(ex_is_overflow), .ex_is_carryOut(ex_is_carryOut),
        .ex_set_flags(ex_set_flags), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_Rd(ex_Rd), .flush(flush), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_Rd(mem_Rd),
        .memalu_result(memalu_result), .read_data(read_data), .mem_done(mem_done),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] sdata;
        logic [3:0]       nzvc;
        logic             set_flags;
        logic             mr;
        logic             mw;
        logic             rw;
        logic [4:0]       rd;
        logic             fl;
    } stim_t;

    typedef struct {
        stim_t            stim;
        logic             exp_valid;
        logic             exp_rw;
        logic             exp_mr;
        logic [4:0]       exp_rd;
        logic [WIDTH-1:0] exp_alu;
        logic [3:0]       exp_nzvc;
    } vec_t;

    // Transaction-level reference: what the stage currently holds and whether an access is pending.
    logic             m_valid, m_rw, m_mr, m_mw, m_busy, m_done;
    logic [4:0]       m_rd;
    logic [WIDTH-1:0] m_alu, m_sd, m_rdata;
    logic [3:0]       m_nzvc;

    function automatic stim_t idleStim();
        stim_t s;
        s = '{valid: 1'b0, alu: '0, sdata: '0, nzvc: 4'b0000, set_flags: 1'b0,
              mr: 1'b0, mw: 1'b0, rw: 1'b0, rd: 5'd0, fl: 1'b0};
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        ex_valid       = s.valid;
        ex_alu_result  = s.alu;
        ex_store_data  = s.sdata;
        {ex_is_neg, ex_is_zero, ex_is_overflow, ex_is_carryOut} = s.nzvc;
        ex_set_flags   = s.set_flags;
        ex_mem_read    = s.mr;
        ex_mem_write   = s.mw;
        ex_reg_write   = s.rw;
        ex_Rd          = s.rd;
        flush          = s.fl;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, 64'(act), 64'(exp));
    endtask

    function automatic logic [3:0] dutFlags();
        return {flag_n, flag_z, flag_v, flag_c};
    endfunction

    task automatic checkAllZero(input string tag);
        checkBit({tag, " mem_stall"}, mem_stall, 1'b0);
        checkBit({tag, " dmem_req"}, dmem_req, 1'b0);
        checkBit({tag, " dmem_we"}, dmem_we, 1'b0);
        checkOutput({tag, " dmem_addr"}, dmem_addr, '0);
        checkOutput({tag, " dmem_wdata"}, dmem_wdata, '0);
        checkBit({tag, " mem_valid"}, mem_valid, 1'b0);
        checkBit({tag, " mem_reg_write"}, mem_reg_write, 1'b0);
        checkBit({tag, " mem_mem_read"}, mem_mem_read, 1'b0);
        checkOutput({tag, " mem_Rd"}, 64'(mem_Rd), '0);
        checkOutput({tag, " read_data"}, read_data, '0);
        checkBit({tag, " mem_done"}, mem_done, 1'b0);
        checkOutput({tag, " nzvc"}, 64'(dutFlags()), '0);
    endtask

    task automatic modelReset();
        {m_valid, m_rw, m_mr, m_mw, m_busy, m_done} = '0;
        m_rd = '0; m_alu = '0; m_sd = '0; m_rdata = '0; m_nzvc = '0;
    endtask

    // One clock edge of the reference, using the inputs that were present at that edge.
    task automatic modelStep();
        logic nv;
        nv = ex_valid & ~flush;
        if (m_busy) begin
            m_done = dmem_ready;
            if (dmem_ready) begin
                m_busy = 1'b0;
                if (m_mr && !m_mw) m_rdata = dmem_rdata;
            end
        end else begin
            m_done  = 1'b0;
            m_valid = nv;
            m_rw    = nv & ex_reg_write;
            m_mr    = nv & ex_mem_read;
            m_mw    = nv & ex_mem_write;
            m_rd    = ex_Rd;
            m_alu   = ex_alu_result;
            m_sd    = ex_store_data;
            if (nv && ex_set_flags) m_nzvc = {ex_is_neg, ex_is_zero, ex_is_overflow, ex_is_carryOut};
            m_busy  = nv & (ex_mem_read | ex_mem_write);
        end
    endtask

    function automatic logic [3:0] modelFlags();
`ifdef EX_MEM_FLAG_BYPASS_EN
        if (ex_valid && !flush && ex_set_flags && !m_busy)
            return {ex_is_neg, ex_is_zero, ex_is_overflow, ex_is_carryOut};
`endif
        return m_nzvc;
    endfunction

    task automatic compareModel();
        checkBit("rnd mem_stall", mem_stall, m_busy);
        checkBit("rnd dmem_req", dmem_req, m_busy);
        checkBit("rnd mem_done", mem_done, m_done);
        checkBit("rnd mem_valid", mem_valid, m_valid);
        checkBit("rnd mem_reg_write", mem_reg_write, m_rw);
        checkBit("rnd mem_mem_read", mem_mem_read, m_mr);
        checkOutput("rnd memalu_result", memalu_result, m_alu);
        checkOutput("rnd read_data", read_data, m_rdata);
        checkOutput("rnd flags", 64'(dutFlags()), 64'(modelFlags()));
        if (m_valid) checkOutput("rnd mem_Rd", 64'(mem_Rd), 64'(m_rd));
        if (m_busy) begin
            checkOutput("rnd dmem_addr", dmem_addr, m_alu);
            checkBit("rnd dmem_we", dmem_we, m_mw);
            if (m_mw) checkOutput("rnd dmem_wdata", dmem_wdata, m_sd);
        end
    endtask

    initial begin
        vec_t  vecs[6];
        stim_t s;

        checks = 0;
        failures = 0;
        reset = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        applyStimulus(idleStim());

        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b1;

        // One-cycle instructions; flag expectations accumulate down the table.
        vecs[0] = '{stim: '{1'b1, 64'd15, 64'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0},
                    exp_valid: 1'b1, exp_rw: 1'b1, exp_mr: 1'b0, exp_rd: 5'd3, exp_alu: 64'd15, exp_nzvc: 4'b0000};
        vecs[1] = '{stim: '{1'b1, 64'h5, 64'd0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0},
                    exp_valid: 1'b1, exp_rw: 1'b1, exp_mr: 1'b0, exp_rd: 5'd4, exp_alu: 64'h5, exp_nzvc: 4'b1001};
        vecs[2] = '{stim: '{1'b1, 64'h7, 64'd0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0},
                    exp_valid: 1'b1, exp_rw: 1'b1, exp_mr: 1'b0, exp_rd: 5'd5, exp_alu: 64'h7, exp_nzvc: 4'b1001};
        vecs[3] = '{stim: '{1'b1, 64'h80, 64'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1},
                    exp_valid: 1'b0, exp_rw: 1'b0, exp_mr: 1'b0, exp_rd: 5'd6, exp_alu: 64'h80, exp_nzvc: 4'b1001};
        vecs[4] = '{stim: '{1'b0, 64'h11, 64'd0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0},
                    exp_valid: 1'b0, exp_rw: 1'b0, exp_mr: 1'b0, exp_rd: 5'd7, exp_alu: 64'h11, exp_nzvc: 4'b1001};
        vecs[5] = '{stim: '{1'b1, 64'h22, 64'd0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1},
                    exp_valid: 1'b0, exp_rw: 1'b0, exp_mr: 1'b0, exp_rd: 5'd8, exp_alu: 64'h22, exp_nzvc: 4'b1001};

        for (int i = 0; i < 6; i++) begin
            logic [3:0] prev_flags;
            prev_flags = (i == 0) ? 4'b0000 : vecs[i-1].exp_nzvc;
            @(negedge clk);
            applyStimulus(vecs[i].stim);
            #1;
`ifdef EX_MEM_FLAG_BYPASS_EN
            checkOutput($sformatf("vec%0d bypass flags", i), 64'(dutFlags()),
                        64'((vecs[i].stim.valid && !vecs[i].stim.fl && vecs[i].stim.set_flags) ?
                            vecs[i].stim.nzvc : prev_flags));
`else
            checkOutput($sformatf("vec%0d pre-edge flags", i), 64'(dutFlags()), 64'(prev_flags));
`endif
            @(posedge clk);
            #1;
            checkBit($sformatf("vec%0d mem_valid", i), mem_valid, vecs[i].exp_valid);
            checkBit($sformatf("vec%0d mem_reg_write", i), mem_reg_write, vecs[i].exp_rw);
            checkBit($sformatf("vec%0d mem_mem_read", i), mem_mem_read, vecs[i].exp_mr);
            checkBit($sformatf("vec%0d mem_stall", i), mem_stall, 1'b0);
            checkBit($sformatf("vec%0d dmem_req", i), dmem_req, 1'b0);
            checkBit($sformatf("vec%0d mem_done", i), mem_done, 1'b0);
            checkOutput($sformatf("vec%0d memalu_result", i), memalu_result, vecs[i].exp_alu);
            if (vecs[i].exp_valid) checkOutput($sformatf("vec%0d mem_Rd", i), 64'(mem_Rd), 64'(vecs[i].exp_rd));
            checkOutput($sformatf("vec%0d nzvc", i), 64'(dutFlags()), 64'(vecs[i].exp_nzvc));
        end

        // Load with ready on the third WAIT cycle while an ADD waits upstream.
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h40; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd7;
        applyStimulus(s);
        @(posedge clk); #1;
        checkBit("ld w1 dmem_req", dmem_req, 1'b1);
        checkBit("ld w1 mem_stall", mem_stall, 1'b1);
        checkOutput("ld w1 dmem_addr", dmem_addr, 64'h40);
        checkBit("ld w1 dmem_we", dmem_we, 1'b0);
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h99; s.rw = 1'b1; s.rd = 5'd9;
        applyStimulus(s);
        @(posedge clk); #1;
        checkBit("ld w2 dmem_req", dmem_req, 1'b1);
        checkOutput("ld w2 dmem_addr", dmem_addr, 64'h40);
        checkOutput("ld w2 hold alu", memalu_result, 64'h40);
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 64'hDEAD;
        #1;
        checkBit("ld w3 dmem_req", dmem_req, 1'b1);
        checkBit("ld w3 mem_done", mem_done, 1'b0);
        @(posedge clk); #1;
        checkBit("ld done mem_done", mem_done, 1'b1);
        checkOutput("ld done read_data", read_data, 64'hDEAD);
        checkBit("ld done mem_stall", mem_stall, 1'b0);
        checkBit("ld done dmem_req", dmem_req, 1'b0);
        @(negedge clk);
        dmem_ready = 1'b0; dmem_rdata = 64'hBAD;
        @(posedge clk); #1;
        checkBit("ld after mem_done", mem_done, 1'b0);
        checkOutput("ld after memalu", memalu_result, 64'h99);
        checkOutput("ld after mem_Rd", 64'(mem_Rd), 64'd9);
        checkOutput("ld after read_data", read_data, 64'hDEAD);

        // Store, ready already high at capture (ignored) and in the first WAIT cycle.
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h8; s.sdata = 64'd9; s.mw = 1'b1;
        applyStimulus(s);
        dmem_ready = 1'b1; dmem_rdata = 64'h1234;
        @(posedge clk); #1;
        checkBit("st dmem_req", dmem_req, 1'b1);
        checkBit("st dmem_we", dmem_we, 1'b1);
        checkOutput("st dmem_wdata", dmem_wdata, 64'd9);
        checkOutput("st dmem_addr", dmem_addr, 64'h8);
        @(negedge clk);
        applyStimulus(idleStim());
        @(posedge clk); #1;
        checkBit("st mem_done", mem_done, 1'b1);
        checkBit("st done dmem_req", dmem_req, 1'b0);
        checkOutput("st read_data", read_data, 64'hDEAD);
        @(negedge clk);
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        checkBit("st after mem_done", mem_done, 1'b0);
        checkBit("st after mem_stall", mem_stall, 1'b0);

        // Flush arriving while a load waits must be ignored.
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h100; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd2;
        applyStimulus(s);
        @(posedge clk);
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h200; s.rw = 1'b1; s.fl = 1'b1;
        applyStimulus(s);
        @(posedge clk); #1;
        checkBit("fl wait mem_stall", mem_stall, 1'b1);
        checkBit("fl wait mem_valid", mem_valid, 1'b1);
        checkOutput("fl wait memalu", memalu_result, 64'h100);
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 64'h55;
        @(posedge clk); #1;
        checkBit("fl mem_done", mem_done, 1'b1);
        checkOutput("fl read_data", read_data, 64'h55);
        checkBit("fl done mem_valid", mem_valid, 1'b1);
        @(negedge clk);
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        checkBit("fl bubble mem_valid", mem_valid, 1'b0);
        checkBit("fl bubble dmem_req", dmem_req, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h300; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd1;
        applyStimulus(s);
        @(posedge clk); #1;
        checkBit("rst pre dmem_req", dmem_req, 1'b1);
        @(negedge clk);
        applyStimulus(idleStim());
        #2 reset = 1'b0;
        #1;
        checkAllZero("rst mid-wait");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checkBit("rst after mem_stall", mem_stall, 1'b0);
        @(negedge clk);
        s = idleStim(); s.valid = 1'b1; s.alu = 64'h48; s.mw = 1'b1; s.sdata = 64'h3;
        applyStimulus(s);
        @(posedge clk); #1;
        checkBit("rst after new req", dmem_req, 1'b1);

        // Randomized run against the reference model from a fresh reset.
        @(negedge clk);
        applyStimulus(idleStim());
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            s.valid     = ($urandom_range(0, 9) < 7);
            s.alu       = {$urandom, $urandom};
            s.sdata     = {$urandom, $urandom};
            s.nzvc      = 4'($urandom_range(0, 15));
            s.set_flags = 1'($urandom_range(0, 1));
            s.mr        = ($urandom_range(0, 9) < 2);
            s.mw        = ($urandom_range(0, 9) < 2);
            s.rw        = 1'($urandom_range(0, 1));
            s.rd        = 5'($urandom_range(0, 31));
            s.fl        = ($urandom_range(0, 9) == 0);
            applyStimulus(s);
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = {$urandom, $urandom};
            #1;
            compareModel();
            @(posedge clk);
            modelStep();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
